cbus_arbiter: RTL and testbench
===============================

Name: cbus_arbiter

Overview:
- Shares the single outbound cache bus (cbus_req_t/cbus_resp_t) between N cache-side requesters, e.g. ICache = 0 and DCache = 1, ahead of the memory/AXI bridge.
- Round-robin arbitration at transaction granularity: a grant is held until the final beat (ready & last) completes, so bursts are never interleaved.
- Tracks beats per transaction and flags length mismatches for verification.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- PRIO_INIT, 0, requester index holding highest priority after reset.

Ports:
- clk  in  1  clock.
- reset_  in  1  synchronous active-low reset; sampled on posedge clk.
- ireqs  in  NUM_REQ x cbus_req_t  per-requester bus requests.
- iresps  out  NUM_REQ x cbus_resp_t  per-requester responses.
- oreq  out  cbus_req_t  request to memory side.
- oresp  in  cbus_resp_t  response from memory side.
- busy  out  1  grant currently held.
- grant_idx  out  $clog2(NUM_REQ)  index of current owner; valid when busy=1.
- len_err  out  1  one-cycle pulse on a length mismatch.

Behaviour:
- Reset (reset_=0 at posedge):
  - state=IDLE, busy=0, grant_idx=0, rr_ptr=PRIO_INIT, beat_cnt=0, len_err=0.
  - oreq and all iresps are all-zero combinationally while in IDLE.
  - Reset mid-burst abandons the transaction with no completion beat to the owner. Requesters are reset together, so this is legal.
- States: IDLE, BUSY.
- IDLE:
  - Scan ireqs[k].valid starting at rr_ptr and wrapping modulo NUM_REQ; the first valid index wins.
  - If a winner exists, the next cycle is BUSY with grant_idx=winner and beat_cnt=0. Otherwise stay in IDLE.
  - Arbitration costs exactly 1 cycle: oreq.valid rises the cycle after ireqs[w].valid, and no request is forwarded in the decision cycle.
- BUSY:
  - oreq = ireqs[grant_idx], passed through combinationally.
  - iresps[grant_idx] = oresp; every other iresps[k] = '0 (ready=0, last=0, data=0).
  - On oresp.ready: beat_cnt++.
  - On oresp.ready & oresp.last:
    - Next state IDLE; rr_ptr = (grant_idx+1) mod NUM_REQ.
    - If beat_cnt (pre-increment) != oreq.len, pulse len_err the following cycle. Compare beat index against len, where len encodes beats-1 as in the AXI-style enum.
    - Grant is released regardless of len_err.
- Back-to-back transactions: a completing owner can win again only if no other requester is valid. There is always at least one IDLE cycle between transactions, so minimum issue spacing is last-beat + 2 cycles.
- Owner dropping valid mid-burst is a protocol violation:
  - The arbiter keeps the grant and forwards the request as-is (valid=0) until ready & last.
  - No timeout.
- Requests from non-owners stay pending; their contents are never looked at until they win.
- beat_cnt width is 8 bits (max len 255 beats), with no wrap check beyond that.
- The arbiter does not modify any request field (addr, size, strobe, data, burst, is_write).

Decomposition:
- cbus_req_t, cbus_resp_t and the len encoding come from package common.
- Add arb_state_t (IDLE/BUSY) to common for reuse by a future uncached-path arbiter.
- One natural sub-module, rr_pick: combinational round-robin selector. It takes valid vector and rr_ptr, and returns found and index.
- State, grant, counter and muxing live in cbus_arbiter.

Test Plan:
- Single requester: ireqs[1] valid, addr=0x8000_0040, len=MLEN16. Expect oreq.valid 1 cycle later; 16 ready beats with last on beat 16; iresps[1] mirrors all beats; busy falls the cycle after last; len_err stays 0.
- Simultaneous requests after reset (PRIO_INIT=0): req0 and req1 both valid. Expect req0 served first and iresps[1] all zero meanwhile. Then req1 granted after one IDLE cycle, with rr_ptr=1 while req1 is being granted and rr_ptr=0 after req1 completes.
- Fairness under continuous demand: both requesters always valid with 4-beat bursts. Expect grants alternating 0,1,0,1 over 8 transactions.
- Length mismatch: len=MLEN4 but memory asserts last on beat 2. Expect release after beat 2 and len_err=1 for exactly one cycle.
- Reset mid-burst: reset_=0 on beat 3 of 8. Next cycle busy=0, oreq.valid=0, rr_ptr=PRIO_INIT; a new request after reset_=1 is granted normally.
- Owner drops valid mid-burst: grant holds and oreq.valid=0 is forwarded. Requester 0's pending request is not granted until last is seen.

Source files
------------

// File: rtl/cbus_arbiter_pkg.sv
// Shared cache-bus types: request/response structs, the burst length encoding
// (len = beats - 1) and the arbiter state enum.
package cbus_arbiter_pkg;

  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } cbus_len_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    cbus_len_t   len;
    logic [1:0]  burst;
    logic [7:0]  strobe;
    logic [63:0] data;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [63:0] data;
  } cbus_resp_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cbus_arbiter_if.sv
// Bundle of the arbiter's bus-side signals.
//   ireqs/iresps : per-requester request in / response out
//   oreq/oresp   : memory-side request out / response in
//   busy, grant_idx, len_err : status from the arbiter
// slave  = arbiter view, master = requesters + memory model view.
interface cbus_arbiter_if #(parameter int NUM_REQ = 2);
  import cbus_arbiter_pkg::*;

  localparam int IDXW = idx_width(NUM_REQ);

  cbus_req_t  [NUM_REQ-1:0] ireqs;
  cbus_resp_t [NUM_REQ-1:0] iresps;
  cbus_req_t                oreq;
  cbus_resp_t               oresp;
  logic                     busy;
  logic [IDXW-1:0]          grant_idx;
  logic                     len_err;

  modport slave (
    input  ireqs, oresp,
    output iresps, oreq, busy, grant_idx, len_err
  );

  modport master (
    output ireqs, oresp,
    input  iresps, oreq, busy, grant_idx, len_err
  );

endinterface

// File: rtl/cbus_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   valid : request vector
//   ptr   : index holding highest priority
//   found : some request is valid
//   idx   : first valid index scanning upward from ptr, wrapping
module cbus_arbiter_rr_pick
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDXW    = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDXW-1:0]    ptr,
  output logic               found,
  output logic [IDXW-1:0]    idx
);

  // Scan from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      int c;
      c = (int'(ptr) + i) % NUM_REQ;
      if (valid[c]) begin
        found = 1'b1;
        idx   = IDXW'(c);
      end
    end
  end

endmodule

// File: rtl/cbus_arbiter.sv
// Round-robin arbiter sharing one outbound cache bus between NUM_REQ
// requesters at transaction granularity (grant held until ready & last).
//   clk, reset_ : clock, synchronous active-low reset
//   bus         : ireqs/iresps per requester, oreq/oresp to memory,
//                 busy / grant_idx / len_err status
//
// state | meaning
// IDLE  | no owner; outputs zeroed; pick next owner from rr_ptr
// BUSY  | owner grant_idx; request/response passed through until ready & last
module cbus_arbiter
  import cbus_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int PRIO_INIT = 0
) (
  input  logic            clk,
  input  logic            reset_,
  cbus_arbiter_if.slave   bus
);

  localparam int IDXW = idx_width(NUM_REQ);

  arb_state_t      state;
  logic [IDXW-1:0] grant_idx;
  logic [IDXW-1:0] rr_ptr;
  logic [7:0]      beat_cnt;
  logic            len_err;

  logic [NUM_REQ-1:0] valid_vec;
  logic               pick_found;
  logic [IDXW-1:0]    pick_idx;
  logic [IDXW-1:0]    rr_next;

  cbus_req_t                oreq;
  cbus_resp_t [NUM_REQ-1:0] iresps;

  always_comb begin
    valid_vec = '0;
    for (int k = 0; k < NUM_REQ; k++) valid_vec[k] = bus.ireqs[k].valid;
  end

  cbus_arbiter_rr_pick #(.NUM_REQ(NUM_REQ), .IDXW(IDXW)) u_rr_pick (
    .valid (valid_vec),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign rr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + IDXW'(1);

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state     <= IDLE;
      grant_idx <= '0;
      rr_ptr    <= IDXW'(PRIO_INIT);
      beat_cnt  <= '0;
      len_err   <= 1'b0;
    end else begin
      len_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= BUSY;
            grant_idx <= pick_idx;
            beat_cnt  <= '0;
          end
        end
        BUSY: begin
          if (bus.oresp.ready) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (bus.oresp.last) begin
              state  <= IDLE;
              rr_ptr <= rr_next;
              // beat_cnt is the index of this final beat; len is beats-1.
              if (beat_cnt != 8'(oreq.len)) len_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pass-through muxing; everything reads as zero while no grant is held.
  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (state == BUSY) begin
      oreq              = bus.ireqs[grant_idx];
      iresps[grant_idx] = bus.oresp;
    end
  end

  assign bus.oreq      = oreq;
  assign bus.iresps    = iresps;
  assign bus.busy      = (state == BUSY);
  assign bus.grant_idx = grant_idx;
  assign bus.len_err   = len_err;

endmodule

// File: tb/tb_cbus_arbiter.sv
module tb_cbus_arbiter;
  import cbus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset_ = 1'b0;
  always #5 clk = ~clk;

  cbus_arbiter_if #(.NUM_REQ(2)) bus();

  cbus_arbiter #(.NUM_REQ(2), .PRIO_INIT(0)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .bus    (bus.slave)
  );

  cbus_req_t  req0, req1;
  cbus_resp_t resp;
  assign bus.ireqs[0] = req0;
  assign bus.ireqs[1] = req1;
  assign bus.oresp    = resp;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Inputs for one cycle and the outputs expected just before its clock edge.
  typedef struct {
    logic v0, v1, rdy, lst;
    logic busy, gidx, ov, r0, r1, lerr;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    //             v0 v1 rdy lst  busy gidx ov r0 r1 lerr
    vecs[0]  = '{1, 1, 0, 0,   0, 0, 0, 0, 0, 0};  // decision cycle, rr_ptr=0
    vecs[1]  = '{1, 1, 1, 0,   1, 0, 1, 1, 0, 0};  // req0 beat 0
    vecs[2]  = '{1, 1, 1, 1,   1, 0, 1, 1, 0, 0};  // req0 final beat
    vecs[3]  = '{0, 1, 0, 0,   0, 0, 0, 0, 0, 0};  // mandatory idle
    vecs[4]  = '{1, 1, 1, 0,   1, 1, 1, 0, 1, 0};  // req1 beat 0
    vecs[5]  = '{1, 1, 0, 0,   1, 1, 1, 0, 0, 0};  // wait state
    vecs[6]  = '{1, 1, 1, 1,   1, 1, 1, 0, 1, 0};  // req1 final beat
    vecs[7]  = '{1, 1, 0, 0,   0, 0, 0, 0, 0, 0};  // idle, rr_ptr back to 0
    vecs[8]  = '{1, 0, 1, 1,   1, 0, 1, 1, 0, 0};  // early last on beat 0 of 2
    vecs[9]  = '{1, 0, 0, 0,   0, 0, 0, 0, 0, 1};  // len_err pulse; req0 alone wins again
    vecs[10] = '{0, 0, 0, 0,   1, 0, 0, 0, 0, 0};  // owner dropped valid
    vecs[11] = '{0, 1, 1, 1,   1, 0, 0, 1, 0, 0};  // early last, req1 pending
    vecs[12] = '{0, 0, 0, 0,   0, 0, 0, 0, 0, 1};  // len_err pulse

    req0 = '0; req1 = '0; resp = '0;
    req0.addr = 32'h0000_1000; req0.len = MLEN2;
    req1.addr = 32'h0000_2000; req1.len = MLEN2;

    reset_ = 1'b0;
    repeat (2) tick();
    chk("rst_busy", bus.busy, 0);
    chk("rst_gidx", bus.grant_idx, 0);
    chk("rst_ov", bus.oreq.valid, 0);
    chk("rst_lerr", bus.len_err, 0);
    chk("rst_rrptr", dut.rr_ptr, 0);
    reset_ = 1'b1;

    for (int i = 0; i < 13; i++) begin
      req0.valid = vecs[i].v0;
      req1.valid = vecs[i].v1;
      resp.ready = vecs[i].rdy;
      resp.last  = vecs[i].lst;
      #1;
      chk($sformatf("v%0d_busy", i), bus.busy, vecs[i].busy);
      if (vecs[i].busy) chk($sformatf("v%0d_gidx", i), bus.grant_idx, vecs[i].gidx);
      chk($sformatf("v%0d_ov", i), bus.oreq.valid, vecs[i].ov);
      chk($sformatf("v%0d_r0", i), bus.iresps[0].ready, vecs[i].r0);
      chk($sformatf("v%0d_r1", i), bus.iresps[1].ready, vecs[i].r1);
      chk($sformatf("v%0d_lerr", i), bus.len_err, vecs[i].lerr);
      tick();
    end

    // Single requester, 16-beat burst.
    req0 = '0; resp = '0;
    req1 = '0; req1.valid = 1'b1; req1.addr = 32'h8000_0040; req1.len = MLEN16;
    req1.data = 64'hDEAD_BEEF_0000_0001;
    #1;
    chk("s1_decision_ov", bus.oreq.valid, 0);
    chk("s1_decision_busy", bus.busy, 0);
    tick();
    chk("s1_busy", bus.busy, 1);
    chk("s1_gidx", bus.grant_idx, 1);
    chk("s1_ov", bus.oreq.valid, 1);
    chk("s1_addr", bus.oreq.addr, 64'h8000_0040);
    chk("s1_data", bus.oreq.data, 64'hDEAD_BEEF_0000_0001);
    chk("s1_len", bus.oreq.len, 15);
    for (int b = 0; b < 16; b++) begin
      resp.ready = 1'b1;
      resp.last  = (b == 15);
      resp.data  = 64'hA000 + 64'(b);
      #1;
      chk($sformatf("s1_b%0d_data", b), bus.iresps[1].data, 64'hA000 + 64'(b));
      chk($sformatf("s1_b%0d_last", b), bus.iresps[1].last, (b == 15));
      chk($sformatf("s1_b%0d_r0", b), {bus.iresps[0].ready, bus.iresps[0].last}, 0);
      chk($sformatf("s1_b%0d_d0", b), bus.iresps[0].data, 0);
      tick();
      chk($sformatf("s1_b%0d_busy", b), bus.busy, (b != 15));
      chk($sformatf("s1_b%0d_lerr", b), bus.len_err, 0);
    end
    resp = '0;
    req1.valid = 1'b0;
    tick();
    chk("s1_lerr_after", bus.len_err, 0);

    // Fairness: both always valid, 4-beat bursts.
    req0 = '0; req0.valid = 1'b1; req0.len = MLEN4; req0.addr = 32'h100;
    req1 = '0; req1.valid = 1'b1; req1.len = MLEN4; req1.addr = 32'h200;
    for (int t = 0; t < 8; t++) begin
      n = 0;
      while (!bus.busy && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("fair_t%0d_wait", t), bus.busy, 1);
      chk($sformatf("fair_t%0d_gidx", t), bus.grant_idx, t % 2);
      chk($sformatf("fair_t%0d_rrptr", t), dut.rr_ptr, t % 2);
      chk($sformatf("fair_t%0d_addr", t), bus.oreq.addr, (t % 2) ? 32'h200 : 32'h100);
      for (int b = 0; b < 4; b++) begin
        resp.ready = 1'b1;
        resp.last  = (b == 3);
        tick();
      end
      resp = '0;
      chk($sformatf("fair_t%0d_idle", t), bus.busy, 0);
      chk($sformatf("fair_t%0d_lerr", t), bus.len_err, 0);
    end
    chk("fair_rrptr_end", dut.rr_ptr, 0);
    req0.valid = 1'b0; req1.valid = 1'b0;
    tick();

    // Length mismatch: MLEN4 but last on beat 2.
    req0.valid = 1'b1;
    tick();
    chk("lm_busy", bus.busy, 1);
    chk("lm_gidx", bus.grant_idx, 0);
    resp.ready = 1'b1; resp.last = 1'b0;
    tick();
    resp.last = 1'b1;
    tick();
    req0.valid = 1'b0; resp = '0;
    chk("lm_release", bus.busy, 0);
    chk("lm_lerr_pulse", bus.len_err, 1);
    tick();
    chk("lm_lerr_clear", bus.len_err, 0);
    chk("lm_stay_idle", bus.busy, 0);

    // Reset on beat 3 of 8.
    req0.valid = 1'b1; req0.len = MLEN8;
    tick();
    chk("rm_busy", bus.busy, 1);
    chk("rm_gidx", bus.grant_idx, 0);
    resp.ready = 1'b1;
    repeat (2) tick();
    reset_ = 1'b0;
    tick();
    chk("rm_busy_after", bus.busy, 0);
    chk("rm_ov_after", bus.oreq.valid, 0);
    chk("rm_r0_after", bus.iresps[0].ready, 0);
    chk("rm_rrptr", dut.rr_ptr, 0);
    reset_ = 1'b1;
    req0 = '0; resp = '0;
    req1 = '0; req1.valid = 1'b1; req1.len = MLEN1;
    #1;
    chk("rm_new_decision", bus.oreq.valid, 0);
    tick();
    chk("rm_new_busy", bus.busy, 1);
    chk("rm_new_gidx", bus.grant_idx, 1);
    chk("rm_new_ov", bus.oreq.valid, 1);
    resp.ready = 1'b1; resp.last = 1'b1;
    tick();
    resp = '0; req1.valid = 1'b0;
    chk("rm_new_done", bus.busy, 0);
    chk("rm_new_lerr", bus.len_err, 0);

    // Owner drops valid mid-burst while requester 0 waits.
    req1.valid = 1'b1; req1.len = MLEN4;
    tick();
    chk("dr_busy", bus.busy, 1);
    chk("dr_gidx", bus.grant_idx, 1);
    req1.valid = 1'b0;
    req0 = '0; req0.valid = 1'b1; req0.len = MLEN1;
    for (int c = 0; c < 3; c++) begin
      resp.ready = (c == 1);
      #1;
      chk($sformatf("dr_c%0d_busy", c), bus.busy, 1);
      chk($sformatf("dr_c%0d_gidx", c), bus.grant_idx, 1);
      chk($sformatf("dr_c%0d_ov", c), bus.oreq.valid, 0);
      chk($sformatf("dr_c%0d_r1", c), bus.iresps[1].ready, (c == 1));
      chk($sformatf("dr_c%0d_r0", c), bus.iresps[0].ready, 0);
      tick();
    end
    resp.ready = 1'b1; resp.last = 1'b1;
    tick();
    resp = '0;
    chk("dr_release", bus.busy, 0);
    chk("dr_lerr", bus.len_err, 1);
    tick();
    chk("dr_req0_busy", bus.busy, 1);
    chk("dr_req0_gidx", bus.grant_idx, 0);
    req0.valid = 1'b0;
    resp.ready = 1'b1; resp.last = 1'b1;
    tick();
    resp = '0;
    chk("dr_req0_done", bus.busy, 0);
    chk("dr_req0_lerr", bus.len_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
